// File: rtl/rpn_pkg.sv
// rpn_pkg: shared word width, opcodes and controller state encoding for the RPN evaluator
package rpn_pkg;
    localparam int W = 16;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_END = 2'b11;
    typedef enum logic [3:0] {
        S_IDLE, S_POP_B, S_POP_A, S_EXEC, S_PUSH_R, S_POP_END, S_DONE, S_ERR, S_DRAIN
    } state_t;
endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// rpn_stack_ctrl_if: token stream plus LIFO push/pop port; master is the environment, slave the controller
interface rpn_stack_ctrl_if;
    import rpn_pkg::*;
    logic         tok_valid;
    logic         tok_ready;
    logic         tok_is_op;
    logic [W-1:0] tok_data;
    logic         stk_en;
    logic         stk_rw;
    logic [W-1:0] stk_wdata;
    logic [W-1:0] stk_rdata;
    logic         stk_empty;
    logic         stk_full;
    modport master (
        output tok_valid, tok_is_op, tok_data, stk_rdata, stk_empty, stk_full,
        input  tok_ready, stk_en, stk_rw, stk_wdata
    );
    modport slave (
        input  tok_valid, tok_is_op, tok_data, stk_rdata, stk_empty, stk_full,
        output tok_ready, stk_en, stk_rw, stk_wdata
    );
endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational a op b; wraps modulo 2^W, or saturates signed when RPN_SAT_EN is defined
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] r
);
`ifdef RPN_SAT_EN
    localparam logic signed [2*W-1:0] S_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] S_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    logic signed [2*W-1:0] sa, sb, wide;
    always_comb begin
        sa   = signed'({{W{a[W-1]}}, a});
        sb   = signed'({{W{b[W-1]}}, b});
        wide = op == OP_ADD ? sa + sb : op == OP_SUB ? sa - sb : sa * sb;
        r    = wide > S_MAX ? S_MAX[W-1:0] : wide < S_MIN ? S_MIN[W-1:0] : wide[W-1:0];
    end
`else
    always_comb r = op == OP_ADD ? a + b : op == OP_SUB ? a - b : a * b;
`endif
endmodule

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN token evaluator driving a LIFO stack; EXEC saturation selected by RPN_SAT_EN
module rpn_stack_ctrl
    import rpn_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    rpn_stack_ctrl_if.slave bus,
    input  logic         clr,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic         err_underflow,
    output logic         err_overflow
);
    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, alu_r;
    logic [1:0]   op_q, op_d;
    logic         err_underflow_q, err_underflow_d, err_overflow_q, err_overflow_d;

    rpn_alu u_alu (.a(a_q), .b(b_q), .op(op_q), .r(alu_r));

    assign result        = result_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
    assign busy          = state_q != S_IDLE;

    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        op_d            = op_q;
        result_d        = result_q;
        err_underflow_d = err_underflow_q;
        err_overflow_d  = err_overflow_q;
        bus.tok_ready   = 1'b0;
        bus.stk_en      = 1'b0;
        bus.stk_rw      = 1'b0;
        bus.stk_wdata   = bus.tok_data;
        result_valid    = 1'b0;
        // clr wins over everything, including a token offered in the same cycle
        if (clr && state_q != S_DRAIN) state_d = S_DRAIN;
        else case (state_q)
            S_IDLE: begin
                bus.tok_ready = 1'b1;
                if (bus.tok_valid && !bus.tok_is_op && bus.stk_full) begin
                    err_overflow_d = 1'b1;
                    state_d        = S_ERR;
                end else if (bus.tok_valid && !bus.tok_is_op) bus.stk_en = 1'b1;
                else if (bus.tok_valid && bus.tok_data[1:0] == OP_END) state_d = S_POP_END;
                else if (bus.tok_valid) begin
                    op_d    = bus.tok_data[1:0];
                    state_d = S_POP_B;
                end
            end
            S_POP_B, S_POP_A, S_POP_END: begin
                if (bus.stk_empty) begin
                    err_underflow_d = 1'b1;
                    state_d         = S_ERR;
                end else begin
                    bus.stk_en = 1'b1;
                    bus.stk_rw = 1'b1;
                    b_d        = state_q == S_POP_B ? bus.stk_rdata : b_q;
                    a_d        = state_q == S_POP_A ? bus.stk_rdata : a_q;
                    result_d   = state_q == S_POP_END ? bus.stk_rdata : result_q;
                    state_d    = state_q == S_POP_B ? S_POP_A : state_q == S_POP_A ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: state_d = S_PUSH_R;
            S_PUSH_R: begin
                bus.stk_en    = 1'b1;
                bus.stk_wdata = alu_r;
                state_d       = S_IDLE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: state_d = S_ERR;
            S_DRAIN: begin
                bus.stk_en      = !bus.stk_empty;
                bus.stk_rw      = 1'b1;
                err_underflow_d = bus.stk_empty ? 1'b0 : err_underflow_q;
                err_overflow_d  = bus.stk_empty ? 1'b0 : err_overflow_q;
                state_d         = bus.stk_empty ? S_IDLE : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q         <= S_IDLE;
            a_q             <= '0;
            b_q             <= '0;
            op_q            <= '0;
            result_q        <= '0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            op_q            <= op_d;
            result_q        <= result_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
        end
    end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb_rpn_stack_ctrl: directed and randomized RPN streams against a queue-based evaluator and a LIFO stack model
module tb_rpn_stack_ctrl;
    import rpn_pkg::*;
    localparam int DEPTH = 8;
    typedef struct {logic is_op; logic [W-1:0] d;} tok_t;

    logic Clk = 1'b0, Rst = 1'b0, clr = 1'b0;
    logic [W-1:0] result;
    logic result_valid, busy, err_underflow, err_overflow;
    int n_chk = 0, n_pass = 0;

    rpn_stack_ctrl_if bus ();
    rpn_stack_ctrl dut (
        .Clk(Clk), .Rst(Rst), .bus(bus), .clr(clr), .result(result), .result_valid(result_valid),
        .busy(busy), .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 Clk = ~Clk;

    logic [W-1:0] mem [DEPTH];
    int sp = 0, pop_cnt = 0, rv_cnt = 0;
    assign bus.stk_empty = sp == 0;
    assign bus.stk_full  = sp == DEPTH;
    assign bus.stk_rdata = sp > 0 ? mem[sp-1] : '0;
    always @(posedge Clk) begin
        if (bus.stk_en && !bus.stk_rw && sp < DEPTH) begin
            mem[sp] <= bus.stk_wdata;
            sp <= sp + 1;
        end else if (bus.stk_en && bus.stk_rw && sp > 0) begin
            sp <= sp - 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (result_valid) rv_cnt <= rv_cnt + 1;
    end

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, z;
        x = longint'($signed(a));
        y = longint'($signed(b));
        z = op == OP_ADD ? x + y : op == OP_SUB ? x - y : x * y;
`ifdef RPN_SAT_EN
        if (z > (longint'(1) <<< (W-1)) - 1) z = (longint'(1) <<< (W-1)) - 1;
        if (z < -(longint'(1) <<< (W-1))) z = -(longint'(1) <<< (W-1));
`endif
        return z[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_eval(input tok_t t[$]);
        logic [W-1:0] v[$];
        logic [W-1:0] a, b;
        foreach (t[i]) begin
            if (!t[i].is_op) v.push_back(t[i].d);
            else if (t[i].d[1:0] == OP_END) return v.pop_back();
            else begin
                b = v.pop_back();
                a = v.pop_back();
                v.push_back(ref_op(t[i].d[1:0], a, b));
            end
        end
        return '0;
    endfunction

    task automatic send(input logic is_op, input logic [W-1:0] d);
        int n = 0;
        while (!bus.tok_ready && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            $display("FAIL send_timeout tok_ready=%b required=1", bus.tok_ready);
        end
        bus.tok_valid = 1'b1;
        bus.tok_is_op = is_op;
        bus.tok_data  = d;
        @(negedge Clk);
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            $display("FAIL idle_timeout busy=%b required=0", busy);
        end
    endtask

    task automatic ready_gap(output int n);
        n = 1;
        while (!bus.tok_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #1;
        n_chk++;
        if (bus.tok_ready !== 1'b0) $display("FAIL clr_ready actual=%b required=0", bus.tok_ready); else n_pass++;
        @(negedge Clk);
        clr = 1'b0;
        @(negedge Clk);
        wait_idle();
    endtask

    task automatic test_reset();
        @(negedge Clk);
        n_chk += 6;
        if (bus.tok_ready !== 1'b1) $display("FAIL rst_ready actual=%b required=1", bus.tok_ready); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rst_busy actual=%b required=0", busy); else n_pass++;
        if (result !== '0) $display("FAIL rst_result actual=%h required=0000", result); else n_pass++;
        if (result_valid !== 1'b0) $display("FAIL rst_rv actual=%b required=0", result_valid); else n_pass++;
        if ({err_underflow, err_overflow} !== 2'b00) $display("FAIL rst_err actual=%b required=00", {err_underflow, err_overflow}); else n_pass++;
        if (bus.stk_en !== 1'b0) $display("FAIL rst_stk_en actual=%b required=0", bus.stk_en); else n_pass++;
        Rst = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_add();
        int rv0 = rv_cnt;
        send(0, 3); send(0, 4); send(1, OP_ADD); send(1, OP_END);
        wait_idle();
        @(negedge Clk);
        n_chk += 3;
        if (result !== 16'h0007) $display("FAIL add_result actual=%h required=0007", result); else n_pass++;
        if (rv_cnt - rv0 !== 1) $display("FAIL add_pulses actual=%0d required=1", rv_cnt - rv0); else n_pass++;
        if (sp !== 0) $display("FAIL add_stack_depth actual=%0d required=0", sp); else n_pass++;
    endtask

    task automatic test_latency();
        int g;
        send(0, 10); send(0, 3); send(1, OP_SUB);
        ready_gap(g);
        n_chk++;
        if (g !== 5) $display("FAIL sub_latency actual=%0d required=5", g); else n_pass++;
        send(0, 6); send(1, OP_MUL);
        ready_gap(g);
        n_chk++;
        if (g !== 5) $display("FAIL mul_latency actual=%0d required=5", g); else n_pass++;
        send(1, OP_END);
        wait_idle();
        n_chk++;
        if (result !== 16'h002A) $display("FAIL submul_result actual=%h required=002a", result); else n_pass++;
    endtask

    task automatic test_underflow();
        send(0, 5); send(1, OP_ADD);
        repeat (3) @(negedge Clk);
        n_chk += 4;
        if (err_underflow !== 1'b1) $display("FAIL uf_flag actual=%b required=1", err_underflow); else n_pass++;
        if (busy !== 1'b1) $display("FAIL uf_busy actual=%b required=1", busy); else n_pass++;
        if (bus.tok_ready !== 1'b0) $display("FAIL uf_ready actual=%b required=0", bus.tok_ready); else n_pass++;
        if (err_overflow !== 1'b0) $display("FAIL uf_ovf actual=%b required=0", err_overflow); else n_pass++;
        bus.tok_valid = 1'b1;
        bus.tok_data  = 16'h1234;
        #1;
        n_chk++;
        if (bus.stk_en !== 1'b0) $display("FAIL err_stk_en actual=%b required=0", bus.stk_en); else n_pass++;
        @(negedge Clk);
        bus.tok_valid = 1'b0;
        pulse_clr();
        n_chk += 3;
        if ({err_underflow, err_overflow} !== 2'b00) $display("FAIL uf_clear actual=%b required=00", {err_underflow, err_overflow}); else n_pass++;
        if (sp !== 0) $display("FAIL uf_drain_depth actual=%0d required=0", sp); else n_pass++;
        if (result !== 16'h002A) $display("FAIL uf_result_kept actual=%h required=002a", result); else n_pass++;
    endtask

    task automatic test_sat();
        logic [W-1:0] e1, e2;
`ifdef RPN_SAT_EN
        e1 = 16'h7FFF; e2 = 16'h8000;
`else
        e1 = 16'h8000; e2 = 16'h7FFF;
`endif
        send(0, 16'h7FFF); send(0, 1); send(1, OP_ADD); send(1, OP_END);
        wait_idle();
        n_chk++;
        if (result !== e1) $display("FAIL sat_add actual=%h required=%h", result, e1); else n_pass++;
        send(0, 16'h8000); send(0, 1); send(1, OP_SUB); send(1, OP_END);
        wait_idle();
        n_chk++;
        if (result !== e2) $display("FAIL sat_sub actual=%h required=%h", result, e2); else n_pass++;
    endtask

    task automatic test_overflow();
        int p0;
        for (int i = 0; i < DEPTH; i++) send(0, W'(i + 1));
        bus.tok_valid = 1'b1;
        bus.tok_data  = 16'h00FF;
        #1;
        n_chk++;
        if (bus.stk_en !== 1'b0) $display("FAIL ovf_stk_en actual=%b required=0", bus.stk_en); else n_pass++;
        @(negedge Clk);
        bus.tok_valid = 1'b0;
        n_chk += 3;
        if (err_overflow !== 1'b1) $display("FAIL ovf_flag actual=%b required=1", err_overflow); else n_pass++;
        if (busy !== 1'b1) $display("FAIL ovf_busy actual=%b required=1", busy); else n_pass++;
        if (sp !== DEPTH) $display("FAIL ovf_depth actual=%0d required=%0d", sp, DEPTH); else n_pass++;
        p0 = pop_cnt;
        pulse_clr();
        n_chk += 3;
        if (pop_cnt - p0 !== DEPTH) $display("FAIL ovf_drain_pops actual=%0d required=%0d", pop_cnt - p0, DEPTH); else n_pass++;
        if (sp !== 0) $display("FAIL ovf_drain_depth actual=%0d required=0", sp); else n_pass++;
        if (err_overflow !== 1'b0) $display("FAIL ovf_clear actual=%b required=0", err_overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send(0, 2); send(0, 9); send(1, OP_ADD);
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        n_chk += 4;
        if (bus.tok_ready !== 1'b1) $display("FAIL mid_rst_ready actual=%b required=1", bus.tok_ready); else n_pass++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy actual=%b required=0", busy); else n_pass++;
        if (bus.stk_en !== 1'b0) $display("FAIL mid_rst_stk_en actual=%b required=0", bus.stk_en); else n_pass++;
        if (result !== '0) $display("FAIL mid_rst_result actual=%h required=0000", result); else n_pass++;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        send(0, 2); send(0, 2); send(1, OP_MUL); send(1, OP_END);
        wait_idle();
        n_chk++;
        if (result !== 16'h0004) $display("FAIL mid_rst_mul actual=%h required=0004", result); else n_pass++;
        pulse_clr();
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            tok_t t[$];
            logic [W-1:0] exp_r, v;
            int rv0, extra, n_ops;
            extra = ($urandom_range(0, 3) == 0) ? 1 : 0;
            n_ops = $urandom_range(1, 4);
            for (int k = 0; k < 1 + extra + n_ops; k++) begin
                v = $urandom_range(0, 2) == 0 ? W'($urandom) : W'($urandom_range(0, 20));
                t.push_back('{1'b0, v});
                if (k > extra) t.push_back('{1'b1, W'($urandom_range(0, 2))});
            end
            t.push_back('{1'b1, W'(OP_END)});
            exp_r = ref_eval(t);
            rv0 = rv_cnt;
            foreach (t[i]) send(t[i].is_op, t[i].d);
            wait_idle();
            @(negedge Clk);
            n_chk += 4;
            if (result !== exp_r) $display("FAIL rand_result round=%0d actual=%h required=%h", r, result, exp_r); else n_pass++;
            if (rv_cnt - rv0 !== 1) $display("FAIL rand_pulses round=%0d actual=%0d required=1", r, rv_cnt - rv0); else n_pass++;
            if (sp !== extra) $display("FAIL rand_residue round=%0d actual=%0d required=%0d", r, sp, extra); else n_pass++;
            if ({err_underflow, err_overflow} !== 2'b00) $display("FAIL rand_err round=%0d actual=%b required=00", r, {err_underflow, err_overflow}); else n_pass++;
            if (extra != 0) pulse_clr();
        end
    endtask

    initial begin
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = '0;
        test_reset();
        test_add();
        test_latency();
        test_underflow();
        test_sat();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
